// File: rtl/tdm_demux_if.sv
// Serial-in / frame-out bundle for tdm_demux. The link side drives the master modport
// and the demux takes the slave modport.
interface tdm_demux_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
);
  logic                      ser_in;
  logic                      ser_valid;
  logic                      sync_in;
  logic [CHANNELS*WIDTH-1:0] par_out;
  logic                      par_valid;
  logic                      frame_err;
  logic                      parity_err;

  modport master (
    output ser_in, ser_valid, sync_in,
    input  par_out, par_valid, frame_err, parity_err
  );

  modport slave (
    input  ser_in, ser_valid, sync_in,
    output par_out, par_valid, frame_err, parity_err
  );
endinterface

// File: rtl/tdm_demux.sv
// Bit-interleaved TDM demultiplexer: sync-aligned frame capture, per-channel word assembly.
// Optional trailing even-parity bit enabled by defining DEMUX_PARITY_EN.
module tdm_demux #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
) (
  input logic        clk,
  input logic        reset,
  tdm_demux_if.slave bus
);
  localparam int DATA = CHANNELS * WIDTH;
`ifdef DEMUX_PARITY_EN
  localparam int FRAME = DATA + 1;
`else
  localparam int FRAME = DATA;
`endif
  localparam int CW = $clog2(FRAME);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  typedef enum logic {HUNT, RECV} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FRAME-1:0]  sh_q, sh_d, wr;
  logic [DATA-1:0]   par_q, par_d, asm_w;
  logic              pv_q, pv_d, fe_q, fe_d;
  logic              par_ok;
`ifdef DEMUX_PARITY_EN
  logic              pe_q, pe_d;
`endif

  // Frame buffer as it would look with the current bit written at its slot.
  always_comb begin
    wr        = sh_q;
    wr[cnt_q] = bus.ser_in;
  end

  // Frame bit k belongs to channel k%CHANNELS, word bit k/CHANNELS.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    for (genvar w = 0; w < WIDTH; w++) begin : g_bit
      assign asm_w[c*WIDTH + w] = wr[w*CHANNELS + c];
    end
  end

`ifdef DEMUX_PARITY_EN
  assign par_ok = ~^wr;
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef DEMUX_PARITY_EN
    pe_d    = 1'b0;
`endif
    if (bus.ser_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.sync_in) begin
            sh_d    = '0;
            sh_d[0] = bus.ser_in;
            cnt_d   = CW'(1);
            state_d = RECV;
          end
        end
        RECV: begin
          if (bus.sync_in && cnt_q != '0) begin
            // Early sync: drop the partial frame and restart on this bit.
            fe_d    = 1'b1;
            sh_d    = '0;
            sh_d[0] = bus.ser_in;
            cnt_d   = CW'(1);
          end else if (!bus.sync_in && cnt_q == '0) begin
            fe_d    = 1'b1;
            state_d = HUNT;
          end else begin
            sh_d = wr;
            if (cnt_q == LAST) begin
              cnt_d = '0;
              if (par_ok) begin
                par_d = asm_w;
                pv_d  = 1'b1;
              end
`ifdef DEMUX_PARITY_EN
              else pe_d = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= '0;
      pv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef DEMUX_PARITY_EN
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      pv_q    <= pv_d;
      fe_q    <= fe_d;
`ifdef DEMUX_PARITY_EN
      pe_q    <= pe_d;
`endif
    end
  end

  assign bus.par_out   = par_q;
  assign bus.par_valid = pv_q;
  assign bus.frame_err = fe_q;
`ifdef DEMUX_PARITY_EN
  assign bus.parity_err = pe_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux (CHANNELS=2, WIDTH=4): a queue-based frame model predicts
// output pulses with their cycle; a negedge monitor pops and compares.
module tb_tdm_demux;
  localparam int CH   = 2;
  localparam int W    = 4;
  localparam int DATA = CH * W;
`ifdef DEMUX_PARITY_EN
  localparam int FRAME = DATA + 1;
`else
  localparam int FRAME = DATA;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tdm_demux_if #(.CHANNELS(CH), .WIDTH(W)) bus ();
  tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef enum {EV_PV, EV_FE, EV_PE} ev_kind_t;
  typedef struct {
    ev_kind_t        kind;
    logic [DATA-1:0] data;
    int              cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, errors = 0;
  int  cyc = 0;
  int  pv_cnt = 0, fe_cnt = 0, pe_cnt = 0;
  logic [DATA-1:0] hold = '0;

  bit m_hunt = 1'b1;
  bit m_bits[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  function automatic logic [2:0] kind_bits(input ev_kind_t k);
    case (k)
      EV_PV:   return 3'b100;
      EV_FE:   return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  // Reference: a frame is a list of collected bits; complete when it holds FRAME bits.
  function automatic void model_accept(input bit s, input bit b);
    ev_t e;
    int  ones;
    e.kind = EV_PV;
    e.data = '0;
    e.cyc  = cyc + 1;
    if (m_hunt) begin
      if (s) begin
        m_bits.delete();
        m_bits.push_back(b);
        m_hunt = 1'b0;
      end
    end else if (s && m_bits.size() != 0) begin
      e.kind = EV_FE;
      exp_q.push_back(e);
      m_bits.delete();
      m_bits.push_back(b);
    end else if (!s && m_bits.size() == 0) begin
      e.kind = EV_FE;
      exp_q.push_back(e);
      m_hunt = 1'b1;
    end else begin
      m_bits.push_back(b);
      if (m_bits.size() == FRAME) begin
        ones = 0;
        foreach (m_bits[k]) ones += int'(m_bits[k]);
        for (int k = 0; k < DATA; k++) e.data[(k % CH) * W + k / CH] = m_bits[k];
`ifdef DEMUX_PARITY_EN
        if (ones % 2 != 0) e.kind = EV_PE;
`endif
        exp_q.push_back(e);
        m_bits.delete();
      end
    end
  endfunction

  always @(negedge clk) begin : monitor
    ev_t e;
    if (!reset) begin
      chk("reset_par_out", 64'(bus.par_out), 64'h0);
      chk("reset_pulses", 64'({bus.par_valid, bus.frame_err, bus.parity_err}), 64'h0);
      hold = '0;
    end else begin
      if (bus.par_valid || bus.frame_err || bus.parity_err) begin
        pv_cnt += int'(bus.par_valid);
        fe_cnt += int'(bus.frame_err);
        pe_cnt += int'(bus.parity_err);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got pv/fe/pe=%b expected none (t=%0t)",
                   {bus.par_valid, bus.frame_err, bus.parity_err}, $time);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", 64'({bus.par_valid, bus.frame_err, bus.parity_err}), 64'(kind_bits(e.kind)));
          chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
          if (e.kind == EV_PV) hold = e.data;
        end
      end
      chk("par_out", 64'(bus.par_out), 64'(hold));
    end
  end

  task automatic drive(input bit v, input bit s, input bit b);
    @(negedge clk);
    bus.ser_valid = v;
    bus.sync_in   = s;
    bus.ser_in    = b;
    if (v) model_accept(s, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  function automatic bit fbit(input logic [DATA-1:0] word, input int k, input bit bad_par);
    if (k < DATA) return word[(k % CH) * W + k / CH];
    return (^word) ^ bad_par;
  endfunction

  task automatic send_bits(input logic [DATA-1:0] word, input int nbits, input int gap, input bit bad_par);
    for (int k = 0; k < nbits; k++) begin
      drive(1'b1, k == 0, fbit(word, k, bad_par));
      idle(gap);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.ser_valid = 1'b0;
    #2 reset = 1'b0;
    m_hunt = 1'b1;
    m_bits.delete();
    #1;
    chk("async_clear_par_out", 64'(bus.par_out), 64'h0);
    chk("async_clear_pv", 64'(bus.par_valid), 64'h0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, f0, e0;
    logic [DATA-1:0] wd;
    bus.ser_valid = 1'b0;
    bus.sync_in   = 1'b0;
    bus.ser_in    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;

    // 1: 5A back-to-back bits
    p0 = pv_cnt;
    send_bits(8'h5A, FRAME, 0, 1'b0);
    idle(2);
    chk("t1_par_out", 64'(bus.par_out), 64'h5A);
    chk("t1_pulses", 64'(pv_cnt - p0), 64'd1);

    // 2: same frame with gaps
    p0 = pv_cnt;
    send_bits(8'h5A, FRAME, 3, 1'b0);
    idle(2);
    chk("t2_par_out", 64'(bus.par_out), 64'h5A);
    chk("t2_pulses", 64'(pv_cnt - p0), 64'd1);

    // 3: junk before first sync after a mid-frame reset
    send_bits(8'hFF, 3, 0, 1'b0);
    do_reset();
    f0 = fe_cnt;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1);
    send_bits(8'hC3, FRAME, 0, 1'b0);
    idle(2);
    chk("t3_par_out", 64'(bus.par_out), 64'hC3);
    chk("t3_no_ferr", 64'(fe_cnt - f0), 64'd0);

    // 4: sync arriving at bit 5
    f0 = fe_cnt;
    send_bits(8'hAA, 5, 0, 1'b0);
    send_bits(8'h0F, FRAME, 0, 1'b0);
    idle(2);
    chk("t4_ferr", 64'(fe_cnt - f0), 64'd1);
    chk("t4_par_out", 64'(bus.par_out), 64'h0F);

    // 5: back-to-back frames, stray bit, then hunting ignores non-sync bits
    p0 = pv_cnt;
    f0 = fe_cnt;
    send_bits(8'h5A, FRAME, 0, 1'b0);
    send_bits(8'hA5, FRAME, 0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    idle(2);
    chk("t5_pulses", 64'(pv_cnt - p0), 64'd2);
    chk("t5_ferr", 64'(fe_cnt - f0), 64'd1);
    chk("t5_par_out", 64'(bus.par_out), 64'hA5);

`ifdef DEMUX_PARITY_EN
    // 6: good then bad parity
    e0 = pe_cnt;
    send_bits(8'h5A, FRAME, 0, 1'b0);
    send_bits(8'h33, FRAME, 0, 1'b1);
    idle(2);
    chk("t6_par_out_held", 64'(bus.par_out), 64'h5A);
    chk("t6_parity_err", 64'(pe_cnt - e0), 64'd1);
`else
    e0 = pe_cnt;
`endif

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 19))
        0: do_reset();
        1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11: begin
          wd = DATA'($urandom);
          send_bits(wd, FRAME, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
        end
        default: begin
          for (int j = 0; j < int'($urandom_range(1, 6)); j++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'($urandom));
        end
      endcase
    end
    idle(4);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
`ifndef DEMUX_PARITY_EN
    chk("no_parity_err", 64'(pe_cnt - e0), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
